// File: rtl/rs232_avm_responder.sv
// Avalon-MM responder exposing the RS232 UART register map (RX=0, TX=4, STATUS=8)
// over an RX byte-stream FIFO and a TX byte-stream FIFO.

module rs232_avm_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        push_i,
    input  logic        pop_i,
    input  logic [7:0]  din_i,
    output logic [7:0]  dout_o,
    output logic [AW:0] cnt_o
);
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_q] <= din_i;
    end

    // Callers guarantee push only when not full and pop only when not empty.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + 1'b1;
            if (pop_i)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + {{AW{1'b0}}, push_i} - {{AW{1'b0}}, pop_i};
        end
    end

    assign dout_o = mem_q[rd_q];
    assign cnt_o  = cnt_q;
endmodule

module rs232_avm_responder #(
    parameter int RX_DEPTH    = 4,
    parameter int TX_DEPTH    = 4,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        avm_clk,
    input  logic        avm_rst,
    input  logic [4:0]  avm_address,
    input  logic        avm_read,
    output logic [31:0] avm_readdata,
    input  logic        avm_write,
    input  logic [31:0] avm_writedata,
    output logic        avm_waitrequest,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);
    localparam int RXA = $clog2(RX_DEPTH);
    localparam int TXA = $clog2(TX_DEPTH);
    localparam logic [RXA:0] RX_FULL = RX_DEPTH[RXA:0];
    localparam logic [TXA:0] TX_FULL = TX_DEPTH[TXA:0];
    localparam logic [3:0]   WLOAD   = (WAIT_CYCLES > 0) ? WAIT_CYCLES[3:0] - 4'd1 : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t     state_q, state_d;
    logic [3:0] wcnt_q, wcnt_d;
    logic [4:0] addr_q, addr_d;
    logic       rd_q, rd_d;
    logic [7:0] wdat_q, wdat_d;
    logic       ovf_q, ovf_d;

    logic [RXA:0] rx_cnt;
    logic [TXA:0] tx_cnt;
    logic [7:0]   rx_head, tx_head;
    logic         ack, rx_ne, tx_nf, rx_push, rx_pop, tx_push, tx_pop;
    logic         unused_wdata;

    assign unused_wdata = ^avm_writedata[31:8];

    assign ack      = (state_q == S_ACK);
    assign rx_ne    = (rx_cnt != '0);
    assign tx_nf    = (tx_cnt != TX_FULL);
    assign rx_ready = !avm_rst && (rx_cnt != RX_FULL);
    assign tx_valid = (tx_cnt != '0);
    assign tx_data  = tx_valid ? tx_head : 8'h00;

    assign rx_push  = rx_valid && rx_ready;
    assign tx_pop   = tx_valid && tx_ready;
    assign rx_pop   = ack && rd_q && (addr_q == 5'd0) && rx_ne;
    assign tx_push  = ack && !rd_q && (addr_q == 5'd4) && tx_nf;

    assign avm_waitrequest = !ack;

    // Read data comes only from registered state, so it is stable for the whole ACK cycle.
    always_comb begin
        avm_readdata = 32'h0;
        if (ack && rd_q) begin
            case (addr_q)
                5'd0:    avm_readdata = {24'h0, rx_ne ? rx_head : 8'h00};
                5'd8:    avm_readdata = {24'h0, rx_ne, tx_nf, 5'b0, ovf_q};
                default: avm_readdata = 32'h0;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        addr_d  = addr_q;
        rd_d    = rd_q;
        wdat_d  = wdat_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (avm_read || avm_write) begin
                    addr_d  = avm_address;
                    rd_d    = avm_read;
                    wdat_d  = avm_writedata[7:0];
                    wcnt_d  = WLOAD;
                    state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_ACK;
                end
            end
            S_WAIT: begin
                if (wcnt_q == 4'd0) state_d = S_ACK;
                else                wcnt_d  = wcnt_q - 4'd1;
            end
            S_ACK: begin
                state_d = S_IDLE;
                if (!rd_q && addr_q == 5'd4 && !tx_nf) ovf_d = 1'b1;
                if (rd_q && addr_q == 5'd8)            ovf_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge avm_clk) begin
        if (avm_rst) begin
            state_q <= S_IDLE;
            wcnt_q  <= 4'd0;
            addr_q  <= 5'd0;
            rd_q    <= 1'b0;
            wdat_q  <= 8'h00;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            wdat_q  <= wdat_d;
            ovf_q   <= ovf_d;
        end
    end

    rs232_avm_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk_i (avm_clk), .rst_i (avm_rst),
        .push_i(rx_push), .pop_i (rx_pop),
        .din_i (rx_data), .dout_o(rx_head), .cnt_o (rx_cnt)
    );

    rs232_avm_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk_i (avm_clk), .rst_i (avm_rst),
        .push_i(tx_push), .pop_i (tx_pop),
        .din_i (wdat_q),  .dout_o(tx_head), .cnt_o (tx_cnt)
    );
endmodule

// File: tb/tb_rs232_avm_responder.sv
// Bench for rs232_avm_responder: queue-based reference model checked every cycle,
// directed register-map scenarios with literal expectations, then random traffic.

module tb_rs232_avm_responder;
    localparam int RXD = 4;
    localparam int TXD = 4;
    localparam int W   = 1;

    logic        avm_clk = 1'b0;
    logic        avm_rst = 1'b1;
    logic [4:0]  avm_address = '0;
    logic        avm_read = 1'b0, avm_write = 1'b0;
    logic [31:0] avm_writedata = '0;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;

    rs232_avm_responder #(.RX_DEPTH(RXD), .TX_DEPTH(TXD), .WAIT_CYCLES(W)) dut (
        .avm_clk(avm_clk), .avm_rst(avm_rst), .avm_address(avm_address),
        .avm_read(avm_read), .avm_readdata(avm_readdata), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    always #5 avm_clk = ~avm_clk;

    int nchecks = 0;
    int nerrors = 0;
    bit chk_on  = 1'b0;
    bit rnd_on  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: byte queues plus one pending access with cycles remaining until ACK.
    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    bit         m_ovf = 0, m_busy = 0, m_rd = 0;
    int         m_left = 0;
    logic [4:0] m_addr = '0;
    logic [7:0] m_wd = '0;

    function automatic bit m_ack();
        return m_busy && (m_left == 0);
    endfunction

    function automatic logic [31:0] m_readdata();
        if (!(m_ack() && m_rd)) return 32'h0;
        if (m_addr == 5'd0) return (rxq.size() > 0) ? {24'h0, rxq[0]} : 32'h0;
        if (m_addr == 5'd8)
            return {24'h0, rxq.size() > 0, txq.size() < TXD, 5'b0, m_ovf};
        return 32'h0;
    endfunction

    always @(posedge avm_clk) begin
        if (avm_rst) begin
            rxq.delete(); txq.delete();
            m_ovf = 0; m_busy = 0; m_left = 0;
        end else begin
            automatic bit ack    = m_ack();
            automatic bit txfull = (txq.size() == TXD);
            automatic bit rxfull = (rxq.size() == RXD);
            if (ack && m_rd && m_addr == 5'd0 && rxq.size() > 0) void'(rxq.pop_front());
            if (rx_valid && !rxfull) rxq.push_back(rx_data);
            if (tx_ready && txq.size() > 0) void'(txq.pop_front());
            if (ack && !m_rd && m_addr == 5'd4) begin
                if (txfull) m_ovf = 1;
                else        txq.push_back(m_wd);
            end
            if (ack && m_rd && m_addr == 5'd8) m_ovf = 0;
            if (ack) m_busy = 0;
            else if (m_busy) m_left--;
            else if (avm_read || avm_write) begin
                m_busy = 1; m_left = W;
                m_addr = avm_address; m_rd = avm_read; m_wd = avm_writedata[7:0];
            end
        end
    end

    always @(negedge avm_clk) begin
        if (chk_on) begin
            chk("waitrequest", {31'b0, avm_waitrequest}, {31'b0, !m_ack()});
            chk("readdata", avm_readdata, m_readdata());
            chk("rx_ready", {31'b0, rx_ready}, {31'b0, !avm_rst && rxq.size() < RXD});
            chk("tx_valid", {31'b0, tx_valid}, {31'b0, txq.size() > 0});
            chk("tx_data", {24'b0, tx_data}, (txq.size() > 0) ? {24'b0, txq[0]} : 32'h0);
        end
    end

    always begin
        @(posedge avm_clk); #1;
        if (rnd_on) begin
            rx_valid = ($urandom_range(0, 1) == 1);
            rx_data  = 8'($urandom);
            tx_ready = ($urandom_range(0, 2) != 0);
        end
    end

    task automatic tick();
        @(posedge avm_clk); #1;
    endtask

    // Starts and ends at posedge+1. Optional scramble drops the request and changes
    // address/data once the access has been sampled.
    task automatic do_access(input logic [4:0] a, input bit rd, input bit wr,
                             input logic [7:0] wd, input bit scramble,
                             output logic [31:0] data, output int lat);
        bit done = 0;
        avm_address = a; avm_read = rd; avm_write = wr;
        avm_writedata = {24'hDEAD_BE, wd};
        data = 32'h0; lat = 0;
        for (int n = 1; n <= 20 && !done; n++) begin
            @(negedge avm_clk);
            if (!avm_waitrequest) begin
                data = avm_readdata; lat = n; done = 1;
            end else if (scramble && n == 2) begin
                avm_address = 5'($urandom); avm_writedata = $urandom;
                avm_read = 0; avm_write = 0;
            end
        end
        if (!done) chk("access_timeout", 32'h0, 32'h1);
        tick();
        avm_read = 0; avm_write = 0;
    endtask

    logic [31:0] rd;
    int          lat;
    logic [7:0]  seen[$];
    logic [4:0]  addrs[6] = '{5'd0, 5'd4, 5'd8, 5'd12, 5'd1, 5'd31};

    initial begin
        tick(); tick();
        chk_on = 1;
        @(negedge avm_clk);
        chk("rst_waitrequest", {31'b0, avm_waitrequest}, 32'h1);
        chk("rst_rx_ready", {31'b0, rx_ready}, 32'h0);
        chk("rst_readdata", avm_readdata, 32'h0);
        tick();
        avm_rst = 0;
        @(negedge avm_clk);
        chk("post_rst_rx_ready", {31'b0, rx_ready}, 32'h1);
        chk("post_rst_tx_valid", {31'b0, tx_valid}, 32'h0);
        tick();

        do_access(5'd8, 1, 0, 8'h0, 0, rd, lat);
        chk("status_after_reset", rd, 32'h40);
        chk("access_latency", lat, 32'd3);

        rx_valid = 1; rx_data = 8'hA5; tick(); rx_valid = 0;
        do_access(5'd8, 1, 0, 8'h0, 0, rd, lat); chk("status_rx_ok", rd, 32'hC0);
        do_access(5'd0, 1, 0, 8'h0, 0, rd, lat); chk("rx_read_a5", rd, 32'hA5);
        do_access(5'd8, 1, 0, 8'h0, 0, rd, lat); chk("status_rx_empty", rd, 32'h40);
        do_access(5'd0, 1, 0, 8'h0, 0, rd, lat); chk("rx_read_empty", rd, 32'h0);

        tx_ready = 0;
        for (int i = 1; i <= 5; i++) do_access(5'd4, 0, 1, 8'(i * 8'h11), 0, rd, lat);
        do_access(5'd8, 1, 0, 8'h0, 0, rd, lat); chk("status_tx_ovf", rd, 32'h01);
        do_access(5'd8, 1, 0, 8'h0, 0, rd, lat); chk("status_ovf_clr", rd, 32'h00);
        tx_ready = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge avm_clk);
            if (tx_valid) seen.push_back(tx_data);
        end
        tick();
        tx_ready = 0;
        chk("tx_drain_count", seen.size(), 32'd4);
        for (int i = 0; i < seen.size() && i < 4; i++)
            chk("tx_drain_byte", {24'b0, seen[i]}, 32'(8'h11 * (i + 1)));

        for (int i = 1; i <= 5; i++) begin
            rx_valid = 1; rx_data = 8'(i); tick();
        end
        do_access(5'd0, 1, 0, 8'h0, 0, rd, lat); chk("rx_full_oldest", rd, 32'h01);
        @(negedge avm_clk);
        chk("rx_ready_after_pop", {31'b0, rx_ready}, 32'h1);
        tick(); rx_valid = 0;
        for (int i = 2; i <= 5; i++) begin
            do_access(5'd0, 1, 0, 8'h0, 0, rd, lat);
            chk("rx_order", rd, 32'(i));
        end

        do_access(5'd4, 1, 1, 8'h77, 0, rd, lat); chk("rd_wr_collision", rd, 32'h0);
        @(negedge avm_clk);
        chk("collision_no_push", {31'b0, tx_valid}, 32'h0);
        tick();

        rx_valid = 1; rx_data = 8'h3C; tick(); rx_valid = 0;
        avm_address = 5'd0; avm_read = 1; tick();
        avm_read = 0; avm_rst = 1;
        @(negedge avm_clk);
        chk("abort_waitrequest", {31'b0, avm_waitrequest}, 32'h1);
        tick(); tick(); avm_rst = 0; tick();
        do_access(5'd8, 1, 0, 8'h0, 0, rd, lat); chk("status_after_abort", rd, 32'h40);

        rnd_on = 1;
        for (int i = 0; i < 300; i++) begin
            automatic bit r = ($urandom_range(0, 1) == 1);
            automatic bit w = !r || ($urandom_range(0, 7) == 0);
            do_access(addrs[$urandom_range(0, 5)], r, w, 8'($urandom),
                      ($urandom_range(0, 3) == 0), rd, lat);
            repeat ($urandom_range(0, 2)) tick();
        end
        rnd_on = 0;
        tick();
        rx_valid = 0; tx_ready = 0;
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end
endmodule

// File: doc/rs232_avm_responder.md
# rs232_avm_responder

Avalon-MM slave that presents the RS232 UART register map (RX data at 0, TX data at 4, STATUS at 8; RX_OK bit 7, TX_OK bit 6) to a polling master such as the RSA wrapper. Behind the register map it holds a receive FIFO, filled from an upstream byte stream, and a transmit FIFO, drained to a downstream byte stream. It serves as the bench-side and loopback-side counterpart of the UART IP, so RSA front-ends can be simulated and integrated without the physical serial port.

## Interface
- RX_DEPTH, 4: receive FIFO entries; must be a power of two, at least 2.
- TX_DEPTH, 4: transmit FIFO entries; must be a power of two, at least 2.
- WAIT_CYCLES, 1: wait-state cycles inserted before each access completes; range 0–15.
- avm_clk  in  1  single clock; all logic on its rising edge.
- avm_rst  in  1  reset, synchronous, active-high.
- avm_address  in  5  byte address: 0 = RX, 4 = TX, 8 = STATUS.
- avm_read  in  1  read request.
- avm_readdata  out  32  read data; valid only in the ACK cycle of a read.
- avm_write  in  1  write request.
- avm_writedata  in  32  write data; only bits [7:0] are used.
- avm_waitrequest  out  1  high except in the single ACK cycle.
- rx_data  in  8  upstream byte.
- rx_valid  in  1  upstream byte valid.
- rx_ready  out  1  high when the RX FIFO is not full.
- tx_data  out  8  head of the TX FIFO.
- tx_valid  out  1  high when the TX FIFO is not empty.
- tx_ready  in  1  downstream accepts the byte.

## Operation
- Access FSM has three states: IDLE, WAIT, ACK.
  - IDLE: waitrequest=1. If read or write is sampled high, latch address, a read flag and writedata[7:0]. Go to WAIT if WAIT_CYCLES>0, otherwise go to ACK.
  - WAIT: count WAIT_CYCLES cycles, then go to ACK.
  - ACK: waitrequest=0 for exactly one cycle. Side effects take effect at the end of this cycle. Always return to IDLE.
- If read and write are both high in IDLE, the access is a read and the write is discarded.
- Only the values latched in IDLE are used. Changes to address or data during WAIT are ignored.
- If the master drops its request during WAIT, the access still completes, including side effects.
- Read at address 0 (RX): readdata = {24'b0, RX head}, and the RX FIFO pops. If the FIFO is empty, readdata = 0 and nothing pops.
- Write at address 4 (TX): push byte if the TX FIFO is not full. If full, drop the byte and set sticky bit tx_ovf.
- Read at address 8 (STATUS) returns:
  - bit7 RX_OK = RX FIFO not empty.
  - bit6 TX_OK = TX FIFO not full.
  - bit0 tx_ovf.
  - All other bits 0.
  - Status is computed from FIFO counts in the ACK cycle. A STATUS read clears tx_ovf at the end of ACK.
- Reads of address 4 and of any unmapped address return 0. Writes to 0, 8 or unmapped addresses are ignored.
- RX push happens when rx_valid && rx_ready.
- TX pop happens when tx_valid && tx_ready. tx_data is the FIFO head, stable while tx_valid is high and tx_ready is low.
- FIFOs use wrapping pointers of log2(depth) bits plus a count of log2(depth)+1 bits.
- rx_ready and TX_OK are derived from the registered count. A full FIFO stays not-ready in a cycle where it also pops.
- A simultaneous push and pop on the same FIFO both occur and leave the count unchanged.

## Timing
- While avm_rst is high, and in the first cycle after it falls, the outputs are:
  - waitrequest=1, readdata=0
  - rx_ready=0 during reset, 1 after
  - tx_valid=0, tx_data=0
  - FIFOs empty, tx_ovf=0, FSM in IDLE
- Access latency is WAIT_CYCLES+1 cycles from the IDLE sample to the ACK cycle. With WAIT_CYCLES=0, ACK is the cycle immediately after the sample.
- Back-to-back accesses need one IDLE cycle between them, so throughput is one access per WAIT_CYCLES+2 cycles.
- readdata is registered, nonzero only in ACK, and 0 in all other cycles.
- A byte pushed into the RX FIFO at edge k is visible to an RX read or STATUS read whose ACK cycle starts at or after k.
- A TX push at the end of ACK makes tx_valid=1 in the next cycle.
- Reset asserted mid-access aborts the access. No FIFO side effect occurs and waitrequest stays 1.

## Test plan
- Reset, then a STATUS read with WAIT_CYCLES=1 → waitrequest low exactly 2 cycles after the request is sampled; readdata=0x40.
- Push 0xA5 via rx_valid, then STATUS read → 0xC0. Then RX read → 0xA5. Then STATUS read → 0x40.
- RX read on an empty FIFO → readdata=0 and the FIFO count is unchanged.
- With tx_ready=0, write 0x11, 0x22, 0x33, 0x44, 0x55:
  - STATUS reads 0x01 (TX_OK=0, tx_ovf=1); a second STATUS read returns 0x00.
  - Then tx_ready=1: tx_data sequence is 0x11, 0x22, 0x33, 0x44 and 0x55 never appears.
- With the RX FIFO full (4 bytes) and rx_valid held high, an RX read returns the oldest byte. rx_ready stays 0 through the ACK edge and goes to 1 the next cycle; the held byte is then accepted, and the order is preserved.
- Assert read and write together at address 4 → readdata=0 and no TX push.
- Assert avm_rst during WAIT of an RX read with 1 byte queued → after reset, STATUS reads 0x40.
